// File: rtl/axis_packet_collector.sv
// Merges PORT_COUNT AXI-Stream packet streams into one, round-robin and packet-atomic, tagging beats with source index.
// Latency: one cycle to grant from IDLE, then one cycle from input handshake to m_axis_collector_tvalid.
// Backpressure: a stalled output register holds all m_* outputs and deasserts ready to the granted port.
module axis_packet_collector #(
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_DEST_WIDTH = 2,
  parameter int PORT_COUNT      = 2 ** AXIS_DEST_WIDTH,
  parameter int COUNTER_WIDTH   = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [PORT_COUNT*AXIS_DATA_WIDTH-1:0] s_axis_collector_tdata,
  input  logic [PORT_COUNT*AXIS_KEEP_WIDTH-1:0] s_axis_collector_tkeep,
  input  logic [PORT_COUNT-1:0]                 s_axis_collector_tvalid,
  input  logic [PORT_COUNT-1:0]                 s_axis_collector_tlast,
  output logic [PORT_COUNT-1:0]                 s_axis_collector_tready,
  output logic [AXIS_DATA_WIDTH-1:0]            m_axis_collector_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]            m_axis_collector_tkeep,
  output logic                                  m_axis_collector_tvalid,
  output logic                                  m_axis_collector_tlast,
  output logic [AXIS_DEST_WIDTH-1:0]            m_axis_collector_tid,
  input  logic                                  m_axis_collector_tready,
  input  logic                                  enable_collector,
  input  logic                                  rst_pkt_counter,
  output logic [COUNTER_WIDTH-1:0]              reg_pkt_counter
);

  typedef enum logic {IDLE, FORWARD} state_t;

  state_t                     state, state_nxt;
  logic [AXIS_DEST_WIDTH-1:0] grant, last_grant;
  logic [AXIS_DEST_WIDTH-1:0] pick, cand;
  logic                       pick_vld;
  logic                       in_rdy, in_hs, in_eop, out_hs;

  // Rotating priority: start one past the last granted port and wrap.
  always_comb begin
    pick     = last_grant;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = 1; i <= PORT_COUNT; i++) begin
      cand = AXIS_DEST_WIDTH'((int'(last_grant) + i) % PORT_COUNT);
      if (!pick_vld && s_axis_collector_tvalid[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  assign in_rdy = (state == FORWARD) && (!m_axis_collector_tvalid || m_axis_collector_tready);
  assign in_hs  = in_rdy && s_axis_collector_tvalid[grant];
  assign in_eop = in_hs && s_axis_collector_tlast[grant];
  assign out_hs = m_axis_collector_tvalid && m_axis_collector_tready;

  always_comb begin
    s_axis_collector_tready        = '0;
    s_axis_collector_tready[grant] = in_rdy;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable_collector && pick_vld) state_nxt = FORWARD;
      FORWARD: if (in_eop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                   <= IDLE;
      grant                   <= '0;
      last_grant              <= AXIS_DEST_WIDTH'(PORT_COUNT - 1);
      m_axis_collector_tvalid <= 1'b0;
      m_axis_collector_tlast  <= 1'b0;
      m_axis_collector_tdata  <= '0;
      m_axis_collector_tkeep  <= '0;
      m_axis_collector_tid    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == FORWARD) grant <= pick;
      if (in_eop) last_grant <= grant;
      if (in_hs) begin
        m_axis_collector_tvalid <= 1'b1;
        m_axis_collector_tdata  <= s_axis_collector_tdata[grant*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
        m_axis_collector_tkeep  <= s_axis_collector_tkeep[grant*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
        m_axis_collector_tlast  <= s_axis_collector_tlast[grant];
        m_axis_collector_tid    <= grant;
      end else if (m_axis_collector_tready) begin
        m_axis_collector_tvalid <= 1'b0;
      end
    end
  end

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || rst_pkt_counter) begin
      reg_pkt_counter <= '0;
    end else if (out_hs && m_axis_collector_tlast && reg_pkt_counter != {COUNTER_WIDTH{1'b1}}) begin
      reg_pkt_counter <= reg_pkt_counter + 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_packet_collector.sv
// Scoreboard bench for axis_packet_collector: per-port packet sources, expected beats queued in hand-chosen order.
module tb_axis_packet_collector;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int IW = 2;
  localparam int PC = 4;
  localparam int CW = 4;

  typedef struct packed {
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [PC*DW-1:0] s_tdata = '0;
  logic [PC*KW-1:0] s_tkeep = '0;
  logic [PC-1:0]    s_tvalid = '0;
  logic [PC-1:0]    s_tlast = '0;
  logic [PC-1:0]    s_tready;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tvalid;
  logic             m_tlast;
  logic [IW-1:0]    m_tid;
  logic             m_tready = 1'b1;
  logic             enable = 1'b1;
  logic             rst_pkt_counter = 1'b0;
  logic [CW-1:0]    pkt_counter;

  beat_t       port_q[PC][$];
  exp_t        sb_q[$];
  logic [PC-1:0] hs = '0;
  int          n_cmp = 0;
  int          n_fail = 0;

  axis_packet_collector #(
    .AXIS_DATA_WIDTH(DW),
    .AXIS_DEST_WIDTH(IW),
    .COUNTER_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis_collector_tdata(s_tdata),
    .s_axis_collector_tkeep(s_tkeep),
    .s_axis_collector_tvalid(s_tvalid),
    .s_axis_collector_tlast(s_tlast),
    .s_axis_collector_tready(s_tready),
    .m_axis_collector_tdata(m_tdata),
    .m_axis_collector_tkeep(m_tkeep),
    .m_axis_collector_tvalid(m_tvalid),
    .m_axis_collector_tlast(m_tlast),
    .m_axis_collector_tid(m_tid),
    .m_axis_collector_tready(m_tready),
    .enable_collector(enable),
    .rst_pkt_counter(rst_pkt_counter),
    .reg_pkt_counter(pkt_counter)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk_data(input int p, input logic [7:0] base, input int b);
    logic [7:0] lo;
    lo = base + 8'(b);
    return {8'(p), 48'h0, lo};
  endfunction

  function automatic logic [KW-1:0] mk_keep(input int b, input int n);
    return (b == n - 1) ? 8'h0F : 8'hFF;
  endfunction

  task automatic send(input int p, input int n, input logic [7:0] base);
    beat_t bt;
    for (int b = 0; b < n; b++) begin
      bt.last = (b == n - 1);
      bt.keep = mk_keep(b, n);
      bt.data = mk_data(p, base, b);
      port_q[p].push_back(bt);
    end
  endtask

  task automatic exp_pkt(input int p, input int n, input logic [7:0] base);
    exp_t e;
    for (int b = 0; b < n; b++) begin
      e.id   = IW'(p);
      e.last = (b == n - 1);
      e.keep = mk_keep(b, n);
      e.data = mk_data(p, base, b);
      sb_q.push_back(e);
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out, %0d beats still expected", name, sb_q.size());
  endtask

  task automatic wait_q(input int n, input string name);
    int k = 0;
    while (sb_q.size() > n && k < 500) begin
      @(posedge clk); #2;
      k++;
    end
    if (sb_q.size() > n) timeout(name);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((sb_q.size() > 0 || m_tvalid) && k < 500) begin
      @(posedge clk); #2;
      k++;
    end
    if (sb_q.size() > 0 || m_tvalid) timeout(name);
  endtask

  task automatic wait_vld(input string name);
    int k = 0;
    while (!m_tvalid && k < 100) begin
      @(posedge clk); #2;
      k++;
    end
    if (!m_tvalid) timeout(name);
  endtask

  // Input handshakes are sampled mid-cycle, sources advance just after the edge.
  always @(negedge clk) hs = s_tvalid & s_tready;

  always @(posedge clk) begin
    #1;
    for (int p = 0; p < PC; p++) begin
      if (rst) port_q[p].delete();
      else if (hs[p] && port_q[p].size() > 0) void'(port_q[p].pop_front());
      if (port_q[p].size() > 0) begin
        s_tvalid[p]            = 1'b1;
        s_tlast[p]             = port_q[p][0].last;
        s_tkeep[p*KW +: KW]    = port_q[p][0].keep;
        s_tdata[p*DW +: DW]    = port_q[p][0].data;
      end else begin
        s_tvalid[p] = 1'b0;
        s_tlast[p]  = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && m_tvalid && m_tready) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got id=%0d data=%0h, want no beat", m_tid, m_tdata);
      end else begin
        e = sb_q.pop_front();
        if ({m_tid, m_tlast, m_tkeep, m_tdata} !== e) begin
          n_fail++;
          $display("FAIL beat: got id=%0d last=%b keep=%0h data=%0h, want id=%0d last=%b keep=%0h data=%0h",
                   m_tid, m_tlast, m_tkeep, m_tdata, e.id, e.last, e.keep, e.data);
        end
      end
    end
  end

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #2;
    check("rst_m_tvalid", 64'(m_tvalid), 0);
    check("rst_m_tlast", 64'(m_tlast), 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tkeep", 64'(m_tkeep), 0);
    check("rst_m_tid", 64'(m_tid), 0);
    check("rst_s_tready", 64'(s_tready), 0);
    check("rst_counter", 64'(pkt_counter), 0);
    rst = 1'b0;

    // Single packet on port 2: grant cycle plus register cycle.
    @(posedge clk); #2;
    send(2, 3, 8'hA1);
    exp_pkt(2, 3, 8'hA1);
    @(posedge clk);
    lat = 0;
    do begin
      @(posedge clk); #2;
      lat++;
    end while (!m_tvalid && lat < 20);
    check("first_latency", 64'(lat), 2);
    wait_drain("port2_pkt");
    check("counter_after_1", 64'(pkt_counter), 1);

    // All ports pending after reset: 0,1,2,3 then port 0 again.
    rst = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b0;
    check("counter_after_rst", 64'(pkt_counter), 0);
    send(0, 2, 8'h10);
    send(0, 2, 8'h50);
    send(1, 2, 8'h20);
    send(2, 2, 8'h30);
    send(3, 2, 8'h40);
    exp_pkt(0, 2, 8'h10);
    exp_pkt(1, 2, 8'h20);
    exp_pkt(2, 2, 8'h30);
    exp_pkt(3, 2, 8'h40);
    exp_pkt(0, 2, 8'h50);
    wait_drain("round_robin");
    check("counter_after_rr", 64'(pkt_counter), 5);

    // Downstream stall for 5 cycles on the first beat.
    send(1, 4, 8'hB1);
    exp_pkt(1, 4, 8'hB1);
    wait_vld("stall_first");
    m_tready = 1'b0;
    repeat (5) begin
      @(posedge clk); #2;
      check("stall_tvalid", 64'(m_tvalid), 1);
      check("stall_tdata", m_tdata, {8'h01, 48'h0, 8'hB1});
      check("stall_tlast_tid", {m_tlast, m_tid}, {1'b0, 2'd1});
      check("stall_s_tready", 64'(s_tready), 0);
    end
    m_tready = 1'b1;
    wait_drain("stall_resume");
    check("counter_after_stall", 64'(pkt_counter), 6);

    // Disable mid-packet: port 1 finishes, port 3 waits.
    send(1, 4, 8'hC1);
    exp_pkt(1, 4, 8'hC1);
    wait_vld("enable_first");
    enable = 1'b0;
    send(3, 1, 8'hD1);
    exp_pkt(3, 1, 8'hD1);
    wait_q(1, "enable_port1_done");
    @(posedge clk); #2;
    repeat (5) begin
      @(posedge clk); #2;
      check("disabled_tvalid", 64'(m_tvalid), 0);
      check("disabled_s_tready", 64'(s_tready), 0);
    end
    enable = 1'b1;
    wait_drain("enable_resume");
    check("counter_after_enable", 64'(pkt_counter), 8);

    // Counter clear, saturation, and clear winning over increment.
    rst_pkt_counter = 1'b1;
    @(posedge clk); #2;
    rst_pkt_counter = 1'b0;
    check("counter_clear", 64'(pkt_counter), 0);
    for (int i = 0; i < 15; i++) begin
      send(0, 1, 8'(i));
      exp_pkt(0, 1, 8'(i));
    end
    wait_drain("fill_counter");
    check("counter_full", 64'(pkt_counter), 15);
    send(0, 1, 8'hE0);
    exp_pkt(0, 1, 8'hE0);
    wait_drain("saturate");
    check("counter_saturated", 64'(pkt_counter), 15);
    rst_pkt_counter = 1'b1;
    @(posedge clk); #2;
    rst_pkt_counter = 1'b0;
    check("counter_clear2", 64'(pkt_counter), 0);
    m_tready = 1'b0;
    send(0, 1, 8'hEE);
    exp_pkt(0, 1, 8'hEE);
    wait_vld("clear_vs_inc");
    rst_pkt_counter = 1'b1;
    m_tready = 1'b1;
    @(posedge clk); #2;
    rst_pkt_counter = 1'b0;
    check("counter_clear_wins", 64'(pkt_counter), 0);
    wait_drain("clear_vs_inc_drain");

    // Reset after two delivered beats of a 5-beat packet.
    send(2, 5, 8'h61);
    exp_pkt(2, 5, 8'h61);
    wait_q(3, "mid_reset_two_beats");
    rst = 1'b1;
    @(posedge clk); #2;
    check("midrst_m_tvalid", 64'(m_tvalid), 0);
    check("midrst_s_tready", 64'(s_tready), 0);
    sb_q.delete();
    rst = 1'b0;
    send(3, 1, 8'h73);
    send(0, 1, 8'h70);
    exp_pkt(0, 1, 8'h70);
    exp_pkt(3, 1, 8'h73);
    wait_drain("post_reset_order");
    check("counter_post_reset", 64'(pkt_counter), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_packet_collector.md
Name: axis_packet_collector

Overview:
Egress-side counterpart of the packet dispatcher. It merges PORT_COUNT AXI-Stream packet streams, indexed by destination, back into one stream toward the interface module. Arbitration is round-robin and packet-atomic. Each output beat carries the index of the source port, and a host-visible counter tracks forwarded packets.

Parameters:
AXIS_DATA_WIDTH, 64, data width per stream
AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width per stream
AXIS_DEST_WIDTH, 2, width of the source index on m_axis_collector_tid
PORT_COUNT, 2**AXIS_DEST_WIDTH, number of input streams
COUNTER_WIDTH, 32, width of the forwarded-packet counter

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous active-high reset
s_axis_collector_tdata  in  PORT_COUNT*AXIS_DATA_WIDTH  input data; port i occupies slice i
s_axis_collector_tkeep  in  PORT_COUNT*AXIS_KEEP_WIDTH  input byte enables, same slicing
s_axis_collector_tvalid  in  PORT_COUNT  per-port valid
s_axis_collector_tlast  in  PORT_COUNT  per-port end of packet
s_axis_collector_tready  out  PORT_COUNT  per-port ready
m_axis_collector_tdata  out  AXIS_DATA_WIDTH  output data
m_axis_collector_tkeep  out  AXIS_KEEP_WIDTH  output byte enables
m_axis_collector_tvalid  out  1  output valid
m_axis_collector_tlast  out  1  output end of packet
m_axis_collector_tid  out  AXIS_DEST_WIDTH  index of the port the beat came from
m_axis_collector_tready  in  1  downstream ready
enable_collector  in  1  allows new grants
rst_pkt_counter  in  1  clears the packet counter
reg_pkt_counter  out  COUNTER_WIDTH  packets forwarded

Behaviour:
- Reset (sync, rst=1):
  - m_tvalid, m_tlast, m_tdata, m_tkeep, m_tid = 0
  - all s_tready = 0
  - reg_pkt_counter = 0
  - state = IDLE
  - last_grant = PORT_COUNT-1, so the first grant goes to port 0
- Reset mid-packet: the partial packet is abandoned, with no tlast emitted. Any register-stage beat is discarded.
- State machine:
  - IDLE → FORWARD: when enable_collector=1 and any s_tvalid=1.
  - Grant choice: the first port with tvalid=1, scanning from (last_grant+1) mod PORT_COUNT upward with wrap. The grant is registered.
  - FORWARD → IDLE: on the input handshake of the granted port when that beat has tlast=1. last_grant takes the granted index in the same cycle.
- In IDLE, all s_tready = 0.
- Arbitration overhead: exactly one IDLE cycle between consecutive packets.
- s_tready:
  - s_tready[grant] = (state==FORWARD) && (!m_tvalid || m_tready).
  - All other s_tready bits = 0.
- Output register:
  - A single-entry register stage.
  - Latency is 1 cycle from input handshake to m_tvalid.
  - Loaded on an input handshake with data, keep, tlast and tid=grant.
  - m_tvalid clears on an output handshake with no simultaneous load.
  - Full throughput of 1 beat/cycle within a packet while m_tready=1.
- Backpressure: while m_tvalid=1 and m_tready=0, all m_* outputs hold stable (AXIS rule) and s_tready[grant]=0.
- Input tvalid dropping mid-packet: the grant is held and the state stays FORWARD. Packets are never interleaved.
- enable_collector=0:
  - In FORWARD, the current packet completes normally.
  - In IDLE, no new grant is made.
  - Pending inputs stay stalled, not dropped.
- Counter:
  - Increments by 1 on each output handshake with m_tlast=1.
  - Saturates at all-ones.
  - rst_pkt_counter=1 forces 0 next cycle. If clear and increment occur in the same cycle, the clear wins.
- Single-beat packets (tlast on the first beat): FORWARD lasts one handshake, then IDLE.
- No tkeep checking; tkeep is passed through unchanged.

Test Plan:
- Port 2 sends 3 beats (0xA1, 0xA2, 0xA3 with tlast), m_tready=1 → 3 output beats with tid=2, first m_tvalid 2 cycles after the port's tvalid (grant + register), tlast on 0xA3, reg_pkt_counter=1.
- Ports 0–3 each hold a 2-beat packet valid simultaneously after reset → output order 0, 1, 2, 3, then 0 again; packets are contiguous and never interleaved.
- Mid-packet, m_tready=0 for 5 cycles → m_tdata/tlast/tid stable, granted s_tready=0; resume → no beat lost or duplicated.
- Drop enable_collector on beat 2 of a 4-beat packet on port 1 → all 4 beats are delivered; a pending port 3 packet gets no grant until enable=1.
- Preload reg_pkt_counter to all-ones by forcing, complete a packet → value stays all-ones; assert rst_pkt_counter together with a tlast handshake → counter reads 0.
- Assert rst after 2 beats of a 5-beat packet → next cycle m_tvalid=0 and s_tready=0; after release, a new packet on port 0 is granted first.
